// File: rtl/anc_lms_mc_core.sv
// anc_lms_mc_core: CHANNELS independent LMS adaptive FIR filters sharing one
// time-multiplexed multiply/accumulate. Each accepted sample is processed as:
// weight update (optional), delay-line shift, then a TAPS-cycle FIR.
// Build option: define ANC_LEAKAGE_EN for leaky LMS (w -= w >>> LEAK_SHIFT).
module anc_lms_mc_core #(
  parameter int DATA_W     = 16,
  parameter int TAPS       = 128,
  parameter int CHANNELS   = 2,
  parameter int FRAC_W     = 15,
  parameter int LEAK_SHIFT = 10,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] e_in,
  input  logic signed [DATA_W-1:0] u_in,
  input  logic                     adapt_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [DATA_W-1:0] out_sample
);

  localparam int K_W   = $clog2(TAPS);
  localparam int PW    = 2 * DATA_W;
  localparam int ACC_W = 2 * DATA_W + K_W;
  localparam int SW    = ACC_W + 2;
  localparam logic signed [SW-1:0] SMAX = SW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] SMIN = SW'(-(64'sd1 <<< (DATA_W - 1)));

  typedef enum logic [2:0] {S_IDLE, S_UPD, S_SHIFT, S_MAC, S_DONE} state_t;

  // Clamp a wide signed value into the DATA_W sample range.
  function automatic logic signed [DATA_W-1:0] sat_w(input logic signed [SW-1:0] v);
    if (v > SMAX) return SMAX[DATA_W-1:0];
    else if (v < SMIN) return SMIN[DATA_W-1:0];
    else return v[DATA_W-1:0];
  endfunction

  state_t                     r_state;
  logic [CH_W-1:0]            r_ch;
  logic [K_W-1:0]             r_k;
  logic signed [DATA_W-1:0]   r_xin;
  logic signed [DATA_W-1:0]   r_mu_e;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_out_valid;
  logic [CH_W-1:0]            r_out_ch;
  logic signed [DATA_W-1:0]   r_out_sample;
  logic signed [DATA_W-1:0]   r_w [CHANNELS][TAPS];
  logic signed [DATA_W-1:0]   r_x [CHANNELS][TAPS];

  logic signed [DATA_W-1:0]   w_wk;
  logic signed [DATA_W-1:0]   w_xk;
  logic signed [PW-1:0]       w_mue_prod;
  logic signed [DATA_W-1:0]   w_mue;
  logic signed [PW-1:0]       w_upd_prod;
  logic signed [DATA_W-1:0]   w_delta;
  logic signed [DATA_W-1:0]   w_wnew;
  logic signed [PW-1:0]       w_mac_prod;
  logic signed [ACC_W-1:0]    w_acc_next;
  logic signed [DATA_W-1:0]   w_mac_out;
  logic [CH_W-1:0]            w_in_ch;
  logic                       w_k_last;

  // The leak shift must be non-negative; this empty branch keeps the
  // parameter referenced in builds without leakage.
  if (LEAK_SHIFT < 0) begin : g_leak_shift_invalid
  end

  assign w_wk       = r_w[r_ch][r_k];
  assign w_xk       = r_x[r_ch][r_k];
  assign w_k_last   = (r_k == K_W'(TAPS - 1));
  // Out-of-range channel requests are still accepted, but routed to channel 0.
  assign w_in_ch    = ({1'b0, in_ch} >= (CH_W + 1)'(CHANNELS)) ? '0 : in_ch;

  // Step-scaled error, formed once when the sample is captured.
  assign w_mue_prod = PW'(u_in) * PW'(e_in);
  assign w_mue      = sat_w(SW'(w_mue_prod >>> FRAC_W));

  // Per-tap weight correction uses the delay line before this sample's shift.
  assign w_upd_prod = PW'(r_mu_e) * PW'(w_xk);
  assign w_delta    = sat_w(SW'(w_upd_prod >>> FRAC_W));
`ifdef ANC_LEAKAGE_EN
  assign w_wnew     = sat_w(SW'(w_wk) - (SW'(w_wk) >>> LEAK_SHIFT) + SW'(w_delta));
`else
  assign w_wnew     = sat_w(SW'(w_wk) + SW'(w_delta));
`endif

  // FIR accumulation is wide enough that TAPS full-scale products never overflow.
  assign w_mac_prod = PW'(w_wk) * PW'(w_xk);
  assign w_acc_next = r_acc + ACC_W'(w_mac_prod);
  assign w_mac_out  = sat_w(SW'(w_acc_next >>> FRAC_W));

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = r_out_valid;
  assign out_ch     = r_out_ch;
  assign out_sample = r_out_sample;

  // Sequencer: capture, walk the tap index through UPD/SHIFT/MAC, hold result until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ch         <= '0;
      r_k          <= '0;
      r_xin        <= '0;
      r_mu_e       <= '0;
      r_acc        <= '0;
      r_out_valid  <= 1'b0;
      r_out_ch     <= '0;
      r_out_sample <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_ch    <= w_in_ch;
            r_xin   <= x_in;
            r_mu_e  <= w_mue;
            r_k     <= '0;
            r_acc   <= '0;
            r_state <= adapt_en ? S_UPD : S_SHIFT;
          end
        end
        S_UPD: begin
          r_k <= r_k + K_W'(1);
          if (w_k_last) r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_k     <= '0;
          r_acc   <= '0;
          r_state <= S_MAC;
        end
        S_MAC: begin
          r_acc <= w_acc_next;
          r_k   <= r_k + K_W'(1);
          if (w_k_last) begin
            r_out_sample <= w_mac_out;
            r_out_ch     <= r_ch;
            r_out_valid  <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Weight banks and delay lines: only the active channel is written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int k = 0; k < TAPS; k++) begin
          r_w[c][k] <= '0;
          r_x[c][k] <= '0;
        end
      end
    end else begin
      if (r_state == S_UPD) r_w[r_ch][r_k] <= w_wnew;
      if (r_state == S_SHIFT) begin
        for (int k = TAPS - 1; k >= 1; k--) r_x[r_ch][k] <= r_x[r_ch][k-1];
        r_x[r_ch][0] <= r_xin;
      end
    end
  end

endmodule

// File: doc/anc_lms_mc_core.md
Name: anc_lms_mc_core

Overview:
- Parametrised successor to the single-channel ANC controller/FIR pair: one block holds CHANNELS independent LMS adaptive FIR filters.
- Each filter has its own weight bank and delay line, served by one time-multiplexed multiplier/accumulator.
- Per accepted sample it performs the weight update first, then shifts in the new input, then runs the FIR.
- Sits between the sample front-end (x/e/u per channel) and the anti-noise DAC path.

Parameters:
DATA_W, 16, sample/weight/step width (signed, Q1.(DATA_W-1))
TAPS, 128, filter length per channel (power of 2, >=4)
CHANNELS, 2, independent filters (>=1)
FRAC_W, 15, fractional bits removed after each product
LEAK_SHIFT, 10, leakage shift; used only with ANC_LEAKAGE_EN

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  sample request valid
in_ready  out  1  high only in IDLE
in_ch  in  max(1,clog2(CHANNELS))  target channel
x_in  in  DATA_W  new reference sample
e_in  in  DATA_W  error sample, belongs to previous output of in_ch
u_in  in  DATA_W  step size
adapt_en  in  1  1 = run weight update for this sample
out_valid  out  1  result valid, held until accepted
out_ready  in  1  downstream accept
out_ch  out  same as in_ch  channel of out_sample
out_sample  out  DATA_W  saturated FIR output

Behaviour:
- Reset (asynchronous, any state including mid-operation):
  - all weights and delay lines = 0, state = IDLE.
  - in_ready = 1 after reset release; out_valid = 0, out_sample = 0, out_ch = 0.
- FSM states: IDLE, UPD, SHIFT, MAC, DONE.
- IDLE:
  - in_valid && in_ready captures in_ch, x_in, e_in, u_in, adapt_en.
  - Next state is UPD if adapt_en = 1, else SHIFT.
  - in_ch >= CHANNELS: request is accepted, channel forced to 0.
- UPD (TAPS cycles, index k = 0..TAPS-1):
  - mu_e = sat((u*e) >>> FRAC_W), computed once at capture.
  - w[k] = sat(w[k] + sat((mu_e * x[k]) >>> FRAC_W)), where x[k] is the delay line before the shift.
- SHIFT (1 cycle): x[k] <= x[k-1] for k >= 1; x[0] <= captured x.
- MAC (TAPS cycles):
  - acc += w[k]*x[k].
  - acc width = 2*DATA_W + clog2(TAPS); no internal overflow.
- Leaving MAC: out_sample = sat(acc >>> FRAC_W) to DATA_W; out_ch = channel; out_valid = 1; state = DONE.
- Latency from the accepting edge:
  - out_valid is high after edge 2*TAPS+1 with adapt_en = 1.
  - out_valid is high after edge TAPS+1 with adapt_en = 0.
- DONE:
  - out_sample and out_ch are held stable while out_valid && !out_ready.
  - On handshake: out_valid = 0, state = IDLE, in_ready = 1 on the next cycle.
  - No new sample is accepted in the same cycle as the output handshake.
- Rounding and saturation:
  - Rounding is arithmetic shift (truncate toward -inf).
  - sat() clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Channels never share weight or delay state; channels not being processed are untouched.
- in_valid while in_ready = 0 is ignored, with no side effects.

Optional Feature:
- ANC_LEAKAGE_EN defined (leaky LMS):
  - UPD computes w[k] = sat(w[k] - (w[k] >>> LEAK_SHIFT) + delta).
  - Leakage applies only when adapt_en = 1.
- Not defined: plain LMS as above; LEAK_SHIFT is unused; the leak logic is not synthesised.

Test Plan:
- (TAPS=4, CHANNELS=2, DATA_W=16, FRAC_W=15 for all scenarios.)
- Reset, then ch0 x=0x4000, e=0, u=0x4000, adapt_en=1, out_ready=1 -> out_valid after edge 9, out_sample=0x0000, out_ch=0.
- Continue ch0 with x=0x4000, e=0x4000, u=0x4000:
  - mu_e = 0x2000, so w0 = 0x1000.
  - Delay line is {0x4000, 0x4000, 0, 0} -> out_sample = 0x0800.
- Same second sample sent on ch1 instead -> out_sample = 0x0000 (ch1 weights untouched); a later ch0 sample still sees ch0 history.
- adapt_en=0 with preloaded non-zero ch0 weights -> weights unchanged; out_valid after edge 5.
- Saturation: drive w0 to 0x7FFF with repeated x=0x7FFF, e=0x7FFF, u=0x7FFF -> w0 clamps at 0x7FFF, never wraps. Then x=0x7FFF on all taps with w=0x7FFF -> out_sample = 0x7FFF.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid/out_sample/out_ch stable, in_ready=0, in_valid pulses ignored.
  - Assert rst mid-MAC -> immediately out_valid=0, in_ready=1 after release, the next ch0 sample yields 0x0000.
